tmr_irq_ctrl: RTL and testbench

//  Interrupt controller for the 8-bit timer units, placed directly downstream of the timer.

---
 rtl/tmr_irq_ctrl.sv | 143 ++++++++++++++
 tb/tb_tmr_irq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_irq_ctrl.sv
// tmr_irq_ctrl: interrupt controller for the 8-bit timer units.
// Edge-detects the per-channel CMIA/CMIB/OVI levels into pending flags, masks
// them with the enable register, picks the lowest-numbered enabled source and
// presents it to the CPU over an irq_req/irq_vec/irq_ack four-phase handshake.
// Source index: idx = 3*ch + type (type 0=CMIA, 1=CMIB, 2=OVI).
// Optional feature macro: TMR_IRQ_OVERRUN_EN (sticky lost-event flags).
module tmr_irq_ctrl #(
    parameter  int NUM_CH  = 4,
    parameter  int VEC_W   = 4,
    localparam int NUM_SRC = 3 * NUM_CH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  cmia,
    input  logic [NUM_CH-1:0]  cmib,
    input  logic [NUM_CH-1:0]  ovi,
    input  logic               ier_wr,
    input  logic [NUM_SRC-1:0] ier_wdata,
    input  logic               clr_wr,
    input  logic [NUM_SRC-1:0] clr_mask,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    output logic [NUM_SRC-1:0] ier,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_sw;
    logic [NUM_SRC-1:0] clr_ack;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] active;

    // Lowest set index wins; scanning downward leaves the lowest one last.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = VEC_W'(i);
        end
        return r;
    endfunction

    // Flatten the three per-channel buses into the interleaved source vector.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        src = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            src[3*ch + 0] = cmia[ch];
            src[3*ch + 1] = cmib[ch];
            src[3*ch + 2] = ovi[ch];
        end
    end

    assign rise   = src & ~src_q;
    assign active = pending & ier;

    // Clear sources for this cycle: software write-1-to-clear and the CPU ack.
    always_comb begin
        clr_sw  = clr_wr ? clr_mask : '0;
        clr_ack = '0;
        if (state == ST_REQ && irq_ack) clr_ack[irq_vec] = 1'b1;
    end

    // A new edge beats any clear so no event is lost to a coincident clear.
    assign pending_nxt = rise | (pending & ~(clr_sw | clr_ack));

    // Edge-detect history, pending flags and the enable mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            pending <= '0;
            ier     <= '0;
        end else begin
            // NOTE: state is written with non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            src_q   <= src;
            pending <= pending_nxt;
            if (ier_wr) ier <= ier_wdata;
        end
    end

    // Request handshake FSM with registered irq_req/irq_vec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
            irq_vec <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|active) begin
                        irq_vec <= lowest_set(active);
                        irq_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        irq_req <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (!pending[irq_vec] || !ier[irq_vec]) begin
                        irq_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (!irq_ack) state <= ST_IDLE;
                end
                default: begin
                    irq_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TMR_IRQ_OVERRUN_EN
    // Sticky lost-event flags: an edge landing on a still-pending bit keeps
    // that bit set (set beats clear), so the earlier event is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= '0;
        end else begin
            overrun <= (rise & pending) | (overrun & ~clr_sw);
        end
    end
`else
    assign overrun = '0;
`endif

endmodule

// File: tb/tb_tmr_irq_ctrl.sv
// tb_tmr_irq_ctrl: directed bench for tmr_irq_ctrl. A vector table covers the
// basic request/ack flow, priority, no-preemption and back-to-back requests;
// hand-written sequences cover masking, withdrawal, set/clear collision,
// overrun, and asynchronous reset in the middle of a handshake.
module tb_tmr_irq_ctrl;

    localparam int NUM_CH  = 4;
    localparam int NUM_SRC = 12;
    localparam int VEC_W   = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_CH-1:0]  cmia, cmib, ovi;
    logic               ier_wr;
    logic [NUM_SRC-1:0] ier_wdata;
    logic               clr_wr;
    logic [NUM_SRC-1:0] clr_mask;
    logic               irq_ack;
    logic               irq_req;
    logic [VEC_W-1:0]   irq_vec;
    logic [NUM_SRC-1:0] ier;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;

    int checks = 0;
    int errors = 0;

`ifdef TMR_IRQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  cmia;
        logic [3:0]  cmib;
        logic [3:0]  ovi;
        logic        ier_wr;
        logic [11:0] ier_wdata;
        logic        clr_wr;
        logic [11:0] clr_mask;
        logic        ack;
        logic        exp_req;
        logic [3:0]  exp_vec;
        logic [11:0] exp_pend;
        logic [11:0] exp_ier;
    } vec_t;

    vec_t tbl[21];

    tmr_irq_ctrl #(.NUM_CH(NUM_CH), .VEC_W(VEC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmia      (cmia),
        .cmib      (cmib),
        .ovi       (ovi),
        .ier_wr    (ier_wr),
        .ier_wdata (ier_wdata),
        .clr_wr    (clr_wr),
        .clr_mask  (clr_mask),
        .irq_ack   (irq_ack),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .ier       (ier),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [3:0] c_a, input logic [3:0] c_b, input logic [3:0] o,
        input logic iw, input logic [11:0] iwd,
        input logic cw, input logic [11:0] cm, input logic a,
        input logic er, input logic [3:0] ev, input logic [11:0] ep,
        input logic [11:0] ei);
        vec_t v;
        v.cmia = c_a;  v.cmib = c_b;  v.ovi = o;
        v.ier_wr = iw; v.ier_wdata = iwd;
        v.clr_wr = cw; v.clr_mask = cm; v.ack = a;
        v.exp_req = er; v.exp_vec = ev; v.exp_pend = ep; v.exp_ier = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, and sample 1 time unit later.
    task automatic run_step(input vec_t v);
        cmia = v.cmia; cmib = v.cmib; ovi = v.ovi;
        ier_wr = v.ier_wr; ier_wdata = v.ier_wdata;
        clr_wr = v.clr_wr; clr_mask = v.clr_mask; irq_ack = v.ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        run_step(mk(4'h0, 4'h0, 4'h0, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 1'b0, 4'h0, 12'h0, 12'h0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // cmia  cmib  ovi   iw  iwd     cw  cm      ack  req  vec  pend    ier
        tbl[0]  = mk(4'h0, 4'h0, 4'h0, 1, 12'hFFF, 0, 12'h0, 0, 0, 4'h0, 12'h000, 12'hFFF);
        tbl[1]  = mk(4'h1, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h001, 12'hFFF);
        tbl[2]  = mk(4'h1, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 1, 4'h0, 12'h001, 12'hFFF);
        tbl[3]  = mk(4'h1, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 1, 0, 4'h0, 12'h000, 12'hFFF);
        tbl[4]  = mk(4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 1, 0, 4'h0, 12'h000, 12'hFFF);
        tbl[5]  = mk(4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h000, 12'hFFF);
        tbl[6]  = mk(4'h0, 4'h8, 4'h2, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h420, 12'hFFF);
        tbl[7]  = mk(4'h0, 4'h8, 4'h2, 0, 12'h000, 0, 12'h0, 0, 1, 4'h5, 12'h420, 12'hFFF);
        tbl[8]  = mk(4'h0, 4'h8, 4'h2, 0, 12'h000, 0, 12'h0, 1, 0, 4'h5, 12'h400, 12'hFFF);
        tbl[9]  = mk(4'h0, 4'h8, 4'h2, 0, 12'h000, 0, 12'h0, 0, 0, 4'h5, 12'h400, 12'hFFF);
        tbl[10] = mk(4'h0, 4'h8, 4'h2, 0, 12'h000, 0, 12'h0, 0, 1, 4'hA, 12'h400, 12'hFFF);
        tbl[11] = mk(4'h0, 4'h8, 4'h2, 0, 12'h000, 0, 12'h0, 1, 0, 4'hA, 12'h000, 12'hFFF);
        tbl[12] = mk(4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'hA, 12'h000, 12'hFFF);
        tbl[13] = mk(4'h0, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'hA, 12'h400, 12'hFFF);
        tbl[14] = mk(4'h0, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 0, 1, 4'hA, 12'h400, 12'hFFF);
        tbl[15] = mk(4'h1, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 0, 1, 4'hA, 12'h401, 12'hFFF);
        tbl[16] = mk(4'h1, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 1, 0, 4'hA, 12'h001, 12'hFFF);
        tbl[17] = mk(4'h1, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'hA, 12'h001, 12'hFFF);
        tbl[18] = mk(4'h1, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 0, 1, 4'h0, 12'h001, 12'hFFF);
        tbl[19] = mk(4'h1, 4'h8, 4'h0, 0, 12'h000, 0, 12'h0, 1, 0, 4'h0, 12'h000, 12'hFFF);
        tbl[20] = mk(4'h0, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h000, 12'hFFF);

        // Reset state.
        rst_n = 1'b0;
        cmia = '0; cmib = '0; ovi = '0;
        ier_wr = 1'b0; ier_wdata = '0; clr_wr = 1'b0; clr_mask = '0; irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req",     32'(irq_req), 32'h0);
        check("reset_vec",     32'(irq_vec), 32'h0);
        check("reset_ier",     32'(ier),     32'h0);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;

        // Table: single event, priority, no-preemption, back-to-back.
        for (int i = 0; i < 21; i++) begin
            run_step(tbl[i]);
            check($sformatf("tbl%0d_req", i),     32'(irq_req), 32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_vec", i),     32'(irq_vec), 32'(tbl[i].exp_vec));
            check($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].exp_pend));
            check($sformatf("tbl%0d_ier", i),     32'(ier),     32'(tbl[i].exp_ier));
            check($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'h0);
        end

        // Masking: event recorded while disabled, request only after enabling.
        run_step(mk(4'h0, 4'h0, 4'h0, 1, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("mask_ier0", 32'(ier), 32'h0);
        run_step(mk(4'h0, 4'h0, 4'h8, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("mask_pending", 32'(pending), 32'h800);
        run_step(mk(4'h0, 4'h0, 4'h8, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("mask_noreq", 32'(irq_req), 32'h0);
        run_step(mk(4'h0, 4'h0, 4'h8, 1, 12'h800, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("mask_ier800", 32'(ier), 32'h800);
        run_step(mk(4'h0, 4'h0, 4'h8, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("mask_req", 32'(irq_req), 32'h1);
        check("mask_vec", 32'(irq_vec), 32'hB);
        // Withdrawal: software clear before ack drops the request.
        run_step(mk(4'h0, 4'h0, 4'h8, 0, 12'h000, 1, 12'h800, 0, 0, 4'h0, 12'h0, 12'h0));
        check("wd_pending", 32'(pending), 32'h0);
        run_step(mk(4'h0, 4'h0, 4'h8, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("wd_req", 32'(irq_req), 32'h0);
        idle_step();
        check("wd_stay_idle", 32'(irq_req), 32'h0);

        // Set/clear collision on bit 4 (cmib[1]).
        run_step(mk(4'h0, 4'h2, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("coll_set", 32'(pending), 32'h010);
        idle_step();
        run_step(mk(4'h0, 4'h2, 4'h0, 0, 12'h000, 1, 12'h010, 0, 0, 4'h0, 12'h0, 12'h0));
        check("coll_pending", 32'(pending), 32'h010);
        check("coll_overrun", 32'(overrun), OVR_EN ? 32'h010 : 32'h0);
        run_step(mk(4'h0, 4'h2, 4'h0, 0, 12'h000, 1, 12'h010, 0, 0, 4'h0, 12'h0, 12'h0));
        check("coll_clr_pending", 32'(pending), 32'h0);
        check("coll_clr_overrun", 32'(overrun), 32'h0);
        idle_step();

        // Overrun: two cmia[2] edges without ack.
        run_step(mk(4'h4, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ovr_first", 32'(overrun), 32'h0);
        idle_step();
        run_step(mk(4'h4, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ovr_second_pending", 32'(pending), 32'h040);
        check("ovr_second", 32'(overrun), OVR_EN ? 32'h040 : 32'h0);
        run_step(mk(4'h0, 4'h0, 4'h0, 0, 12'h000, 1, 12'h040, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ovr_clear", 32'(overrun), 32'h0);
        check("ovr_clear_pending", 32'(pending), 32'h0);

        // Async reset mid-handshake.
        run_step(mk(4'h0, 4'h0, 4'h0, 1, 12'hFFF, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        run_step(mk(4'h2, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ar_pending", 32'(pending), 32'h008);
        check("ar_noreq_yet", 32'(irq_req), 32'h0);
        run_step(mk(4'h2, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ar_req", 32'(irq_req), 32'h1);
        check("ar_vec", 32'(irq_vec), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req_cleared",     32'(irq_req), 32'h0);
        check("ar_pending_cleared", 32'(pending), 32'h0);
        check("ar_ier_cleared",     32'(ier),     32'h0);
        #3;
        rst_n = 1'b1;
        // cmia[1] still high at release: history reset to 0 logs one event.
        run_step(mk(4'h2, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ar_release_event", 32'(pending), 32'h008);
        run_step(mk(4'h2, 4'h0, 4'h0, 0, 12'h000, 0, 12'h0, 0, 0, 4'h0, 12'h0, 12'h0));
        check("ar_masked_noreq", 32'(irq_req), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
